// File: rtl/adc_spi_reader_if.sv
// adc_spi_reader_if: AXI4-Stream link carrying sign-extended ADC samples to the DMA.
//   tdata  [31:0] sample word
//   tvalid        sample present
//   tready        sink accepts the sample
//   tlast         final sample of a packet
// Modports: master (stream source), slave (stream sink).
interface adc_spi_reader_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/adc_spi_reader.sv
// adc_spi_reader: on each trigger pulse, reads one DATA_WIDTH-bit conversion result MSB first
// from the ADC's SPI output and presents it sign-extended on an AXI4-Stream master, framing
// packets of PACKET_LEN samples with tlast.
// Ports:
//   aclk, aresetn  clock and asynchronous active-low reset
//   trigger        one-cycle pulse starting a readout (ignored and counted as a drop while busy)
//   sck            SPI clock to the ADC, idles low
//   sdo            SPI data from the ADC, already synchronous to aclk
//   m_axis         AXI4-Stream master (tdata/tvalid/tready/tlast)
//   last           one-cycle pulse the cycle after each tlast handshake
//   drop_count     saturating count of lost samples and ignored triggers
module adc_spi_reader #(
    parameter int unsigned DATA_WIDTH = 18,
    parameter int unsigned SCK_DIV    = 2,
    parameter int unsigned PACKET_LEN = 1024
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    trigger,
    output logic                    sck,
    input  logic                    sdo,
    adc_spi_reader_if.master        m_axis,
    output logic                    last,
    output logic [15:0]             drop_count
);

    localparam int unsigned HalfW = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam int unsigned BitW  = $clog2(DATA_WIDTH + 1);
    localparam int unsigned PktW  = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;

    typedef enum logic {StIdle, StShift} state_t;

    state_t                  r_state;
    logic                    r_sck;
    logic [HalfW-1:0]        r_half;
    logic [BitW-1:0]         r_bit;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [31:0]             r_tdata;
    logic                    r_tvalid;
    logic                    r_tlast;
    logic [PktW-1:0]         r_pkt;
    logic                    r_last;
    logic [15:0]             r_drop;

    logic                    w_half_end;
    logic                    w_done;
    logic                    w_hs;
    logic                    w_load;
    logic                    w_ovf;
    logic                    w_trig_drop;
    logic                    w_pkt_end;
    logic [PktW-1:0]         w_pkt_next;
    logic [31:0]             w_sext;
    logic [16:0]             w_drop_sum;
    logic [15:0]             w_drop_next;

    always_comb begin
        w_half_end  = (r_half == HalfW'(SCK_DIV - 1));
        // Readout ends at the close of the final low half-period, once every bit is sampled.
        w_done      = (r_state == StShift) && w_half_end && !r_sck &&
                      (r_bit == BitW'(DATA_WIDTH));
        w_hs        = r_tvalid && m_axis.tready;
        // A handshake on the transfer edge frees the single holding slot.
        w_load      = w_done && (!r_tvalid || w_hs);
        w_ovf       = w_done && !w_load;
        w_trig_drop = trigger && (r_state == StShift);
        w_pkt_end   = (r_pkt == PktW'(PACKET_LEN - 1));
        w_pkt_next  = r_pkt;
        if (w_hs) begin
            w_pkt_next = w_pkt_end ? '0 : r_pkt + PktW'(1);
        end
        w_sext      = 32'($signed(r_shift));
        // Both drop sources can fire on the same edge.
        w_drop_sum  = {1'b0, r_drop} + 17'(w_trig_drop) + 17'(w_ovf);
        w_drop_next = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state  <= StIdle;
            r_sck    <= 1'b0;
            r_half   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_pkt    <= '0;
            r_last   <= 1'b0;
            r_drop   <= '0;
        end else begin
            r_last <= w_hs && r_tlast;
            r_drop <= w_drop_next;
            r_pkt  <= w_pkt_next;

            if (w_load) begin
                r_tdata  <= w_sext;
                r_tvalid <= 1'b1;
                // tlast reflects the position this sample will occupy once presented.
                r_tlast  <= (w_pkt_next == PktW'(PACKET_LEN - 1));
            end else if (w_hs) begin
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
            end

            case (r_state)
                StIdle: begin
                    if (trigger) begin
                        r_state <= StShift;
                        r_sck   <= 1'b1;
                        r_half  <= '0;
                        r_bit   <= '0;
                    end
                end
                StShift: begin
                    if (w_half_end) begin
                        r_half <= '0;
                        if (r_sck) begin
                            // Falling SCK edge: capture the bit the ADC is presenting.
                            r_sck   <= 1'b0;
                            r_shift <= {r_shift[DATA_WIDTH-2:0], sdo};
                            r_bit   <= r_bit + BitW'(1);
                        end else if (w_done) begin
                            r_state <= StIdle;
                        end else begin
                            r_sck <= 1'b1;
                        end
                    end else begin
                        r_half <= r_half + HalfW'(1);
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_sck   <= 1'b0;
                end
            endcase
        end
    end

    assign sck           = r_sck;
    assign m_axis.tdata  = r_tdata;
    assign m_axis.tvalid = r_tvalid;
    assign m_axis.tlast  = r_tlast;
    assign last          = r_last;
    assign drop_count    = r_drop;

endmodule

// File: tb/tb_adc_spi_reader.sv
// tb_adc_spi_reader: directed bench for adc_spi_reader (DATA_WIDTH=18, SCK_DIV=2, PACKET_LEN=4).
// Stimulus pushes hand-computed expected words into a scoreboard queue; a monitor pops and
// compares on every stream handshake and tracks the last pulse.
module tb_adc_spi_reader;

    logic        aclk;
    logic        aresetn;
    logic        trigger;
    logic        sck;
    logic        sdo;
    logic        last;
    logic [15:0] drop_count;

    adc_spi_reader_if axis_if ();

    adc_spi_reader #(
        .DATA_WIDTH (18),
        .SCK_DIV    (2),
        .PACKET_LEN (4)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .trigger    (trigger),
        .sck        (sck),
        .sdo        (sdo),
        .m_axis     (axis_if),
        .last       (last),
        .drop_count (drop_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [31:0] data;
        logic        tlast;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_last_pulses = 0;
    int   sck_rises = 0;
    int   model_pkt = 0;
    int   model_drop = 0;
    logic pend_last = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares each handshake against the scoreboard and checks the last pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                pend_last = 1'b0;
            end else begin
                if (pend_last || last) begin
                    check("last_pulse", 32'(last), 32'(pend_last));
                    if (last) n_last_pulses++;
                end
                pend_last = 1'b0;
                if (axis_if.tvalid && axis_if.tready) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_beat: got tdata %h, required no beat",
                                 axis_if.tdata);
                    end else begin
                        e = sb_q.pop_front();
                        check("tdata", axis_if.tdata, e.data);
                        check("tlast", 32'(axis_if.tlast), 32'(e.tlast));
                        pend_last = e.tlast;
                    end
                end
            end
        end
    end

    initial forever begin
        @(posedge sck);
        sck_rises++;
    end

    // One readout. retrig: edge (after t0) at which a second trigger is sampled, -1 for none.
    // abort_at: cycle after t0 at which reset is asserted, -1 for none.
    task automatic do_read(input logic [17:0] pat, input logic [31:0] exp_data,
                           input bit accept, input bit check_rise,
                           input int retrig, input int abort_at);
        if (abort_at < 0) begin
            if (accept) begin
                sb_q.push_back('{data: exp_data, tlast: (model_pkt == 3)});
                model_pkt = (model_pkt + 1) % 4;
            end else begin
                model_drop++;
            end
        end
        if (retrig >= 0) model_drop++;
        @(posedge aclk);
        #1;
        trigger = 1'b1;
        sdo = pat[17];
        sck_rises = 0;
        @(posedge aclk);
        #1;
        trigger = 1'b0;
        for (int c = 1; c <= 72; c++) begin
            @(posedge aclk);
            #1;
            trigger = (c == retrig - 1);
            if (c == abort_at) begin
                check("sck_high_before_abort", 32'(sck), 32'd1);
                aresetn = 1'b0;
                #1;
                check("abort_sck", 32'(sck), 32'd0);
                check("abort_tvalid", 32'(axis_if.tvalid), 32'd0);
                check("abort_drop", 32'(drop_count), 32'd0);
                model_pkt = 0;
                model_drop = 0;
                @(posedge aclk);
                #1;
                aresetn = 1'b1;
                sdo = 1'b0;
                return;
            end
            if (c < 72) sdo = pat[17 - c / 4];
            if (check_rise && c == 71) check("tvalid_before_72", 32'(axis_if.tvalid), 32'd0);
            if (check_rise && c == 72) begin
                check("tvalid_at_72", 32'(axis_if.tvalid), 32'd1);
                check("sck_idle_low", 32'(sck), 32'd0);
                check("sck_rises", 32'(sck_rises), 32'd18);
            end
        end
        sdo = 1'b0;
    endtask

    logic [17:0] pats8[8] = '{18'h00000, 18'h00001, 18'h1FFFF, 18'h20001,
                              18'h0F0F0, 18'h30F0F, 18'h2AAAA, 18'h15555};
    logic [31:0] exps8[8] = '{32'h00000000, 32'h00000001, 32'h0001FFFF, 32'hFFFE0001,
                              32'h0000F0F0, 32'hFFFF0F0F, 32'hFFFEAAAA, 32'h00015555};
    logic [17:0] pats4[4] = '{18'h0ABCD, 18'h2ABCD, 18'h11111, 18'h3FFFE};
    logic [31:0] exps4[4] = '{32'h0000ABCD, 32'hFFFEABCD, 32'h00011111, 32'hFFFFFFFE};

    initial begin
        int pulses_before;
        aresetn = 1'b0;
        trigger = 1'b0;
        sdo = 1'b0;
        axis_if.tready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_tvalid", 32'(axis_if.tvalid), 32'd0);
        check("rst_tdata", axis_if.tdata, 32'd0);
        check("rst_tlast", 32'(axis_if.tlast), 32'd0);
        check("rst_last", 32'(last), 32'd0);
        check("rst_sck", 32'(sck), 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        repeat (2) @(posedge aclk);

        // Negative and positive single reads.
        do_read(18'h2A5A5, 32'hFFFEA5A5, 1'b1, 1'b1, -1, -1);
        @(posedge aclk);
        #1;
        check("tvalid_one_cycle", 32'(axis_if.tvalid), 32'd0);
        do_read(18'h15A5A, 32'h00015A5A, 1'b1, 1'b1, -1, -1);
        repeat (5) @(posedge aclk);

        // Backpressure: first sample held, next two dropped.
        #1;
        axis_if.tready = 1'b0;
        do_read(18'h3FFFF, 32'hFFFFFFFF, 1'b1, 1'b1, -1, -1);
        repeat (27) @(posedge aclk);
        do_read(18'h00001, 32'h0, 1'b0, 1'b0, -1, -1);
        check("held_tdata_1", axis_if.tdata, 32'hFFFFFFFF);
        check("held_tvalid_1", 32'(axis_if.tvalid), 32'd1);
        repeat (27) @(posedge aclk);
        do_read(18'h20000, 32'h0, 1'b0, 1'b0, -1, -1);
        check("held_tdata_2", axis_if.tdata, 32'hFFFFFFFF);
        check("drop_after_bp", 32'(drop_count), 32'd2);
        @(posedge aclk);
        #1;
        axis_if.tready = 1'b1;
        @(posedge aclk);
        #1;
        check("tvalid_after_release", 32'(axis_if.tvalid), 32'd0);

        // Trigger repeated mid-readout is counted and otherwise ignored.
        do_read(18'h12345, 32'h00012345, 1'b1, 1'b1, 10, -1);
        repeat (3) @(posedge aclk);
        #1;
        check("drop_after_retrig", 32'(drop_count), 32'd3);

        // Packet framing over eight reads.
        pulses_before = n_last_pulses;
        for (int i = 0; i < 8; i++) do_read(pats8[i], exps8[i], 1'b1, 1'b1, -1, -1);
        repeat (3) @(posedge aclk);
        check("last_pulse_count", 32'(n_last_pulses - pulses_before), 32'd2);

        // Reset mid-readout, then packet counter restarts.
        do_read(18'h10000, 32'h00010000, 1'b1, 1'b1, -1, -1);
        do_read(18'h3C3C3, 32'h0, 1'b0, 1'b0, -1, 29);
        repeat (3) @(posedge aclk);
        #1;
        check("post_abort_tvalid", 32'(axis_if.tvalid), 32'd0);
        pulses_before = n_last_pulses;
        for (int i = 0; i < 4; i++) do_read(pats4[i], exps4[i], 1'b1, 1'b1, -1, -1);
        repeat (3) @(posedge aclk);
        #1;
        check("post_abort_last_count", 32'(n_last_pulses - pulses_before), 32'd1);
        check("final_drop", 32'(drop_count), 32'(model_drop));
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
